// File: rtl/sumador_restador_serie.sv
// Digit-serial two's-complement add/subtract unit. It processes DIGIT bits per clock, LSB digit first,
// behind a start/busy/done handshake. Results and flags are registered and held until the next completion.

module fullAdder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module digitAdder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cMsb
);
    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : gBit
        fullAdder uFa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[W];
    // Carry into the top bit of this digit; for the last digit this is the carry into the MSB.
    assign cMsb = c[W-1];
endmodule

module sumador_restador_serie #(
    parameter int NBITS = 8,
    parameter int DIGIT = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic             iOp,
    input  logic [NBITS-1:0] iX,
    input  logic [NBITS-1:0] iY,
    output logic             oBusy,
    output logic             oDone,
    output logic [NBITS-1:0] oS,
    output logic             oCout,
    output logic             oOverflow,
    output logic             oZero
);
    localparam int NDIG = NBITS / DIGIT;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [NBITS-1:0] xReg, yReg, acc, resNext;
    logic             carry;
    logic [KW-1:0]    k;
    logic [DIGIT-1:0] xDig, yDig, dSum;
    logic             dCout, dCmsb, lastDig, accept;

    always_comb begin
        xDig    = xReg[int'(k)*DIGIT +: DIGIT];
        yDig    = yReg[int'(k)*DIGIT +: DIGIT];
        resNext = acc;
        resNext[int'(k)*DIGIT +: DIGIT] = dSum;
    end

    digitAdder #(.W(DIGIT)) uDigit (
        .a    (xDig),
        .b    (yDig),
        .cin  (carry),
        .sum  (dSum),
        .cout (dCout),
        .cMsb (dCmsb)
    );

    assign lastDig = (k == KW'(NDIG - 1));
    assign accept  = iStart && (state == IDLE || state == DONE);
    assign oBusy   = (state == RUN);
    assign oDone   = (state == DONE);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state     <= IDLE;
            xReg      <= '0;
            yReg      <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            k         <= '0;
            oS        <= '0;
            oCout     <= 1'b0;
            oOverflow <= 1'b0;
            oZero     <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    acc[int'(k)*DIGIT +: DIGIT] <= dSum;
                    carry <= dCout;
                    if (lastDig) begin
                        k         <= '0;
                        state     <= DONE;
                        oS        <= resNext;
                        oCout     <= dCout;
                        oOverflow <= dCmsb ^ dCout;
                        oZero     <= (resNext == '0);
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: begin
                    // Subtract is X + ~Y + 1: invert Y here and seed the carry with the op bit.
                    if (accept) begin
                        xReg  <= iX;
                        yReg  <= iY ^ {NBITS{iOp}};
                        carry <= iOp;
                        k     <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sumador_restador_serie.sv
// Directed-vector and random-reference bench for the digit-serial add/subtract unit.
// It covers DIGIT=4/1/8 on 8 bits and DIGIT=4 on 16 bits.

module tb_sumador_restador_serie;
    typedef struct {
        logic       op;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] s;
        logic       c;
        logic       v;
        logic       z;
    } vec_t;

    logic clk, rst;
    logic [2:0] startV;
    logic op8;
    logic [7:0] x8, y8;
    wire [2:0] busyV, doneV, cV, vV, zV;
    wire [2:0][7:0] sV;

    logic start16, op16;
    logic [15:0] x16, y16;
    wire busy16, done16, c16, v16, z16;
    wire [15:0] s16;

    int checks = 0;
    int errors = 0;

    sumador_restador_serie #(.NBITS(8), .DIGIT(4)) uDut4 (
        .iClk(clk), .iRst(rst), .iStart(startV[0]), .iOp(op8), .iX(x8), .iY(y8),
        .oBusy(busyV[0]), .oDone(doneV[0]), .oS(sV[0]), .oCout(cV[0]), .oOverflow(vV[0]), .oZero(zV[0]));
    sumador_restador_serie #(.NBITS(8), .DIGIT(1)) uDut1 (
        .iClk(clk), .iRst(rst), .iStart(startV[1]), .iOp(op8), .iX(x8), .iY(y8),
        .oBusy(busyV[1]), .oDone(doneV[1]), .oS(sV[1]), .oCout(cV[1]), .oOverflow(vV[1]), .oZero(zV[1]));
    sumador_restador_serie #(.NBITS(8), .DIGIT(8)) uDut8 (
        .iClk(clk), .iRst(rst), .iStart(startV[2]), .iOp(op8), .iX(x8), .iY(y8),
        .oBusy(busyV[2]), .oDone(doneV[2]), .oS(sV[2]), .oCout(cV[2]), .oOverflow(vV[2]), .oZero(zV[2]));
    sumador_restador_serie #(.NBITS(16), .DIGIT(4)) uDut16 (
        .iClk(clk), .iRst(rst), .iStart(start16), .iOp(op16), .iX(x16), .iY(y16),
        .oBusy(busy16), .oDone(done16), .oS(s16), .oCout(c16), .oOverflow(v16), .oZero(z16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start one op on 8-bit instance w, scramble operands mid-RUN, and check latency, busy span and results.
    task automatic runOp8(input int w, input vec_t v, input int eLat, input string nm);
        int cyc;
        int busyCnt;
        bit seen;
        @(negedge clk);
        op8 = v.op; x8 = v.x; y8 = v.y; startV[w] = 1'b1;
        @(posedge clk); #1;
        startV[w] = 1'b0;
        x8 = 8'($urandom); y8 = 8'($urandom); op8 = 1'($urandom);
        cyc = 1; busyCnt = 0; seen = 0;
        while (cyc <= 40) begin
            if (doneV[w]) begin
                seen = 1;
                break;
            end
            if (busyV[w]) busyCnt++;
            @(posedge clk); #1;
            cyc++;
        end
        chk({nm, " doneSeen"}, 32'(seen), 1);
        chk({nm, " latency"}, cyc, eLat);
        chk({nm, " busyCycles"}, busyCnt, eLat - 1);
        chk({nm, " s"}, sV[w], v.s);
        chk({nm, " cout"}, cV[w], v.c);
        chk({nm, " ovf"}, vV[w], v.v);
        chk({nm, " zero"}, zV[w], v.z);
        @(posedge clk); #1;
        chk({nm, " donePulse1"}, doneV[w], 0);
        chk({nm, " sHeld"}, sV[w], v.s);
    endtask

    vec_t vecs[9];

    initial begin
        vec_t tmp;
        int cyc;
        bit sawDone;
        logic [7:0] bbX, bbExp;
        logic [15:0] ex, ey, es;
        logic ec, ev, ez;
        logic [18:0] prev;

        vecs[0] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; startV = '0; op8 = 0; x8 = 0; y8 = 0;
        start16 = 0; op16 = 0; x16 = 0; y16 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", busyV[0], 0);
        chk("rst done", doneV[0], 0);
        chk("rst s", sV[0], 0);
        chk("rst cout", cV[0], 0);
        chk("rst ovf", vV[0], 0);
        chk("rst zero", zV[0], 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) runOp8(0, vecs[i], 3, $sformatf("vec%0d", i));
        runOp8(1, vecs[3], 9, "digit1 ff+01");
        runOp8(2, vecs[3], 2, "digit8 ff+01");

        // Start held high: a new op is taken on every DONE edge, operands refreshed once each result shows.
        @(negedge clk);
        op8 = 0; x8 = 8'h01; y8 = 8'h02; startV[0] = 1'b1;
        bbX = 8'h01;
        @(posedge clk); #1;
        for (cyc = 1; cyc <= 9; cyc++) begin
            chk($sformatf("b2b done c%0d", cyc), doneV[0], (cyc % 3 == 0) ? 1 : 0);
            chk($sformatf("b2b busy c%0d", cyc), busyV[0], (cyc % 3 != 0) ? 1 : 0);
            if (cyc % 3 == 0) begin
                bbExp = bbX + 8'h02;
                chk($sformatf("b2b s c%0d", cyc), sV[0], bbExp);
                bbX = bbX + 8'h04;
                x8 = bbX;
                if (cyc == 9) startV[0] = 1'b0;
            end
            if (cyc < 9) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        chk("b2b idle busy", busyV[0], 0);
        chk("b2b idle done", doneV[0], 0);

        // A start pulse with other operands while running must be ignored.
        @(negedge clk);
        op8 = 0; x8 = 8'h10; y8 = 8'h20; startV[0] = 1'b1;
        @(posedge clk); #1;
        op8 = 1; x8 = 8'hAA; y8 = 8'h55;
        @(posedge clk); #1;
        startV[0] = 1'b0;
        @(posedge clk); #1;
        chk("ign done", doneV[0], 1);
        chk("ign s", sV[0], 8'h30);
        @(posedge clk); #1;
        chk("ign no restart busy", busyV[0], 0);
        chk("ign no second done", doneV[0], 0);
        chk("ign s held", sV[0], 8'h30);

        // Reset in the first RUN cycle discards the op.
        @(negedge clk);
        op8 = 1; x8 = 8'h33; y8 = 8'h11; startV[0] = 1'b1;
        @(posedge clk); #1;
        startV[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst busy", busyV[0], 0);
        chk("midrst done", doneV[0], 0);
        chk("midrst s", sV[0], 0);
        chk("midrst cout", cV[0], 0);
        chk("midrst ovf", vV[0], 0);
        chk("midrst zero", zV[0], 0);
        sawDone = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (doneV[0]) sawDone = 1;
        end
        chk("midrst no done", 32'(sawDone), 0);
        tmp = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
        runOp8(0, tmp, 3, "post rst 00-01");

        // Random ops on 16-bit against an arithmetic reference; outputs must hold between done pulses.
        prev = '0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            op16 = 1'($urandom); x16 = 16'($urandom); y16 = 16'($urandom);
            ex = x16; ey = y16;
            if (op16) begin
                es = ex - ey;
                ec = (ex >= ey);
                ev = (ex[15] != ey[15]) && (es[15] != ex[15]);
            end else begin
                {ec, es} = {1'b0, ex} + {1'b0, ey};
                ev = (ex[15] == ey[15]) && (es[15] != ex[15]);
            end
            ez = (es == 16'h0);
            start16 = 1'b1;
            @(posedge clk); #1;
            start16 = 1'b0;
            cyc = 1;
            while (!done16 && cyc <= 20) begin
                chk($sformatf("rnd%0d hold", n), {s16, c16, v16, z16}, prev);
                x16 = 16'($urandom); y16 = 16'($urandom); op16 = 1'($urandom);
                @(posedge clk); #1;
                cyc++;
            end
            chk($sformatf("rnd%0d latency", n), cyc, 5);
            chk($sformatf("rnd%0d result", n), {s16, c16, v16, z16}, {es, ec, ev, ez});
            prev = {es, ec, ev, ez};
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sumador_restador_serie.md
Name: sumador_restador_serie

Overview:
Digit-serial add/subtract unit: an NBITS-wide two's-complement add or subtract processed DIGIT bits per clock, LSB digit first, behind a start/busy/done handshake. It is the area-reduced, multi-cycle generalisation of the combinational ripple adder/subtractor. Results and flags are registered and held stable until the next operation completes. It is used where a datapath can trade latency for a narrow adder.

Parameters:
NBITS, 8, total operand/result width; must be >= 2.
DIGIT, 4, bits processed per cycle; must divide NBITS exactly (DIGIT = NBITS gives single-cycle compute).

Ports:
iClk  input  1  clock; all state updates on rising edge.
iRst  input  1  synchronous, active-high reset.
iStart  input  1  request; sampled only in IDLE or DONE.
iOp  input  1  0 = add (X+Y), 1 = subtract (X-Y); latched with iStart.
iX  input  NBITS  operand X; latched with iStart.
iY  input  NBITS  operand Y; latched with iStart.
oBusy  output  1  high while in RUN.
oDone  output  1  one-cycle pulse; result and flags are valid and updated.
oS  output  NBITS  result register.
oCout  output  1  carry out of MSB (for subtract, 1 = no borrow).
oOverflow  output  1  signed overflow.
oZero  output  1  oS == 0.

Behaviour:
- Clock and reset: one clock, iClk. Reset iRst is synchronous and active-high.
- Reset: state = IDLE. oBusy, oDone, oS, oCout, oOverflow and oZero are all 0. Internal operand, carry and digit-counter registers are cleared. Reset wins over every other condition, including mid-RUN; a partial result is discarded.
- States:
  - IDLE: iStart = 1 latches iX, (iY XOR {NBITS{iOp}}) and the carry register = iOp. The digit counter clears, then next state is RUN.
  - RUN: each edge adds digit k of the latched X and complemented Y, plus the carry register. It writes the DIGIT-bit sum into a shift/accumulate register, updates the carry register and increments k. On the edge that processes the last digit (k = NDIG-1, NDIG = NBITS/DIGIT), next state is DONE.
  - DONE: one cycle. Next state is RUN if iStart = 1 (a new operation is latched as in IDLE); otherwise IDLE.
- Latency: iStart sampled at edge 0 gives oBusy high for cycles 1..NDIG and oDone high in cycle NDIG+1. Throughput is one operation per NDIG+1 cycles when starts are back-to-back.
- Output update:
  - oS, oCout, oOverflow and oZero load on the same edge that enters DONE, and hold otherwise.
  - They never show partial values during RUN.
- Flag rules:
  - oCout = carry out of bit NBITS-1.
  - oOverflow = (carry into bit NBITS-1) XOR (carry out of bit NBITS-1). The carry into the MSB is taken inside the final digit, not at the digit boundary.
  - oZero is computed from the final full result.
- Handshake:
  - iStart during RUN is ignored; no queueing.
  - Operand inputs are don't-care except on the accepting edge. Changing iX, iY or iOp mid-RUN has no effect.
- Width: all arithmetic is modulo 2^NBITS. There is no sign extension and no saturation.

Test Plan:
- NBITS=8, DIGIT=4: add 0x7F+0x01 -> oS=0x80, oCout=0, oOverflow=1, oZero=0. oDone must pulse exactly 3 cycles after the start edge, with oBusy high for 2 cycles.
- NBITS=8, DIGIT=4: sub 0x80-0x01 -> oS=0x7F, oCout=1, oOverflow=1. Sub 0x05-0x05 -> oS=0x00, oCout=1, oOverflow=0, oZero=1.
- NBITS=8, DIGIT=1 and DIGIT=8: add 0xFF+0x01 -> oS=0x00, oCout=1, oOverflow=0, oZero=1. Latency must be 9 and 2 cycles respectively.
- Back-to-back and ignored starts:
  - iStart held high continuously -> a new operation is accepted in every DONE cycle, giving oDone every 3 cycles (DIGIT=4).
  - iStart pulsed mid-RUN with different operands -> ignored, and the first result is unchanged.
  - Operands toggled mid-RUN -> result unaffected.
- Reset mid-operation:
  - Assert iRst in cycle 1 of RUN -> next cycle has all outputs 0 and the block is in IDLE. No oDone pulse follows.
  - A subsequent start computes correctly, e.g. sub 0x00-0x01 -> 0xFF, oCout=0, oOverflow=0.
- Randomised check against a reference model (X op Y) for 1000 operations on NBITS=16, DIGIT=4 -> oS, oCout, oOverflow and oZero must all match, and all outputs must stay stable between oDone pulses.
